// File: rtl/barrera_arbitro.sv
// Purpose: arbitrates entry/exit requests for the shared barrier arm and sequences its motor.
// Latency: every decision taken on cycle N is visible on the registered outputs at cycle N+1.
// Backpressure: none; request levels are sampled only in IDLE, and requests that are still held are re-evaluated on return to IDLE.
module barrera_arbitro #(
    parameter int CAPACITY      = 7,
    parameter int MOTOR_TIMEOUT = 50000,
    parameter int PASS_TIMEOUT  = 500000,
    parameter int CLOSE_DELAY   = 1000,
    parameter int TIMER_W       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_in,
    input  logic       req_out,
    input  logic [2:0] count,
    input  logic       ingreso,
    input  logic       egreso,
    input  logic       obstr,
    input  logic       lim_open,
    input  logic       lim_closed,
    input  logic       fault_clr,
    output logic       motor_up,
    output logic       motor_down,
    output logic       grant_in,
    output logic       grant_out,
    output logic       deny_in,
    output logic       full,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_OPENING   = 3'd1,
        S_WAIT_PASS = 3'd2,
        S_HOLD      = 3'd3,
        S_CLOSING   = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    // Terminal timer values: a state is left on the cycle its timer reads LIMIT-1.
    localparam logic [TIMER_W-1:0] MOTOR_LAST = TIMER_W'(MOTOR_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] PASS_LAST  = TIMER_W'(PASS_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(CLOSE_DELAY - 1);
    localparam int unsigned        CAP_U      = CAPACITY;

    state_t               state_q,      state_d;
    logic [TIMER_W-1:0]   timer_q,      timer_d;
    logic                 last_out_q,   last_out_d;   // 1: most recent grant served exit
    logic                 req_in_q,     req_in_d;
    logic                 motor_up_q,   motor_up_d;
    logic                 motor_down_q, motor_down_d;
    logic                 grant_in_q,   grant_in_d;
    logic                 grant_out_q,  grant_out_d;
    logic                 deny_in_q,    deny_in_d;
    logic                 full_q,       full_d;
    logic                 fault_q,      fault_d;

    logic                 at_cap;
    logic                 in_elig;
    logic                 out_elig;
    logic                 take_in;
    logic                 take_out;
    logic                 pass_match;
    logic                 hold_restart;
    logic [TIMER_W-1:0]   timer_inc;

    // Occupancy and eligibility, shared by the arbiter and the full flag.
    always_comb begin
        at_cap     = (32'(count) >= CAP_U);
        in_elig    = req_in && !at_cap;
        out_elig   = req_out;
        pass_match = (ingreso && grant_in_q) || (egreso && grant_out_q);
        timer_inc  = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    end

    // Round-robin pick between entry and exit; a tie goes opposite to the last grant.
    always_comb begin
        take_in  = 1'b0;
        take_out = 1'b0;
        if (in_elig && out_elig) begin
            take_in  = last_out_q;
            take_out = !last_out_q;
        end else begin
            take_in  = in_elig;
            take_out = out_elig;
        end
    end

    // Next-state, timer and registered-output computation.
    always_comb begin
        state_d      = state_q;
        last_out_d   = last_out_q;
        grant_in_d   = grant_in_q;
        grant_out_d  = grant_out_q;
        deny_in_d    = 1'b0;
        req_in_d     = req_in;
        full_d       = at_cap;
        hold_restart = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (take_in || take_out) begin
                    state_d     = S_OPENING;
                    grant_in_d  = take_in;
                    grant_out_d = take_out;
                    last_out_d  = take_out;
                end else if (req_in && !req_in_q && at_cap) begin
                    // Only the rising edge of a refused request is reported.
                    deny_in_d = 1'b1;
                end
            end
            S_OPENING: begin
                if (lim_open) begin
                    state_d = S_WAIT_PASS;
                end else if (timer_q == MOTOR_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_WAIT_PASS: begin
                // A pulse for the other direction belongs to someone else; ignore it.
                if (pass_match) begin
                    state_d = S_HOLD;
                end else if (timer_q == PASS_LAST) begin
                    state_d = S_CLOSING;
                end
            end
            S_HOLD: begin
                if (obstr) begin
                    hold_restart = 1'b1;
                end else if (timer_q == HOLD_LAST) begin
                    state_d = S_CLOSING;
                end
            end
            S_CLOSING: begin
                // Beam blocked under a descending arm wins over everything else.
                if (obstr) begin
                    state_d = S_OPENING;
                end else if (lim_closed) begin
                    state_d = S_IDLE;
                end else if (timer_q == MOTOR_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        // Both limit switches closed at once means a broken sensor.
        if ((state_q != S_FAULT) && lim_open && lim_closed) begin
            state_d = S_FAULT;
        end

        // Every state change and every obstruction in HOLD restarts timing.
        if ((state_d != state_q) || hold_restart) begin
            timer_d = '0;
        end else begin
            timer_d = timer_inc;
        end

        if ((state_d == S_IDLE) || (state_d == S_FAULT)) begin
            grant_in_d  = 1'b0;
            grant_out_d = 1'b0;
        end
        if (state_d != S_IDLE) begin
            deny_in_d = 1'b0;
        end

        motor_up_d   = (state_d == S_OPENING);
        motor_down_d = (state_d == S_CLOSING);
        fault_d      = (state_d == S_FAULT);
    end

    // State, timer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            last_out_q   <= 1'b1;
            req_in_q     <= 1'b0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            grant_in_q   <= 1'b0;
            grant_out_q  <= 1'b0;
            deny_in_q    <= 1'b0;
            full_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            last_out_q   <= last_out_d;
            req_in_q     <= req_in_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            grant_in_q   <= grant_in_d;
            grant_out_q  <= grant_out_d;
            deny_in_q    <= deny_in_d;
            full_q       <= full_d;
            fault_q      <= fault_d;
        end
    end

    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign grant_in   = grant_in_q;
    assign grant_out  = grant_out_q;
    assign deny_in    = deny_in_q;
    assign full       = full_q;
    assign fault      = fault_q;

    // The motor driver must never be told to go both ways.
    motor_exclusive_a: assert property (@(posedge clk) disable iff (!rst)
        !(motor_up_q && motor_down_q));

endmodule

// File: tb/tb_barrera_arbitro.sv
// Purpose: directed-vector scoreboard bench for the barrier arbiter.
// Latency: expected output-vector changes are queued with the exact cycle they must appear on.
// Backpressure: none; the monitor pops one entry per observed output change.
module tb_barrera_arbitro;

    localparam logic [6:0] MU    = 7'b0000001;
    localparam logic [6:0] MD    = 7'b0000010;
    localparam logic [6:0] G_IN  = 7'b0000100;
    localparam logic [6:0] G_OUT = 7'b0001000;
    localparam logic [6:0] DENY  = 7'b0010000;
    localparam logic [6:0] FULL  = 7'b0100000;
    localparam logic [6:0] FLT   = 7'b1000000;

    typedef struct {
        logic [6:0] vec;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_in = 1'b0, req_out = 1'b0;
    logic [2:0] count = 3'd0;
    logic       ingreso = 1'b0, egreso = 1'b0, obstr = 1'b0;
    logic       lim_open = 1'b0, lim_closed = 1'b1, fault_clr = 1'b0;
    logic       motor_up, motor_down, grant_in, grant_out, deny_in, full, fault;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    barrera_arbitro dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .req_out    (req_out),
        .count      (count),
        .ingreso    (ingreso),
        .egreso     (egreso),
        .obstr      (obstr),
        .lim_open   (lim_open),
        .lim_closed (lim_closed),
        .fault_clr  (fault_clr),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .grant_in   (grant_in),
        .grant_out  (grant_out),
        .deny_in    (deny_in),
        .full       (full),
        .fault      (fault)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [6:0] v, input int c);
        exp_t e;
        e.vec = v;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // One complete open / pass / hold / close sequence for the grant already issued.
    task automatic complete_cycle(input logic [6:0] g);
        logic is_in;
        is_in = g[2];
        lim_closed = 1'b0;
        tick(2);
        lim_open = 1'b1;
        push(g, cyc + 1);
        tick(1);
        if (is_in) egreso = 1'b1; else ingreso = 1'b1;   // wrong-direction pulse
        tick(1);
        egreso = 1'b0; ingreso = 1'b0;
        tick(1);
        if (is_in) ingreso = 1'b1; else egreso = 1'b1;
        tick(1);
        ingreso = 1'b0; egreso = 1'b0; lim_open = 1'b0;
        push(g | MD, cyc + 1000);
        tick(1005);
        lim_closed = 1'b1;
        push(g & FULL, cyc + 1);
        tick(1);
    endtask

    // Monitor: reset-state checks while rst is low, scoreboard pops on every output change.
    initial begin
        logic [6:0] v;
        logic [6:0] prev;
        exp_t       e;
        prev = '0;
        forever begin
            @(negedge clk or negedge rst);
            if (!rst) begin
                #1;
                v = {fault, full, deny_in, grant_out, grant_in, motor_down, motor_up};
                checks++;
                if (v !== 7'd0) begin
                    errors++;
                    $display("FAIL reset_state: got %b at cycle %0d, required 0000000", v, cyc);
                end
                prev = v;
            end else if (done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL pending_expect: %0d entries left, required 0 (next %b at cycle %0d)",
                             exp_q.size(), exp_q[0].vec, exp_q[0].cyc);
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end else begin
                v = {fault, full, deny_in, grant_out, grant_in, motor_down, motor_up};
                if (v !== prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: got %b at cycle %0d, required %b unchanged", v, cyc, prev);
                    end else begin
                        e = exp_q.pop_front();
                        if ((e.vec !== v) || (e.cyc != cyc)) begin
                            errors++;
                            $display("FAIL output_change: got %b at cycle %0d, required %b at cycle %0d",
                                     v, cyc, e.vec, e.cyc);
                        end
                    end
                    prev = v;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Async reset in the middle of OPENING.
        count  = 3'd3;
        req_in = 1'b1;
        push(G_IN | MU, cyc + 1);
        tick(1);
        req_in = 1'b0;
        tick(3);
        #2 rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);

        // Normal entry with count below capacity.
        req_in = 1'b1;
        push(G_IN | MU, cyc + 1);
        tick(1);
        req_in = 1'b0;
        complete_cycle(G_IN);
        tick(2);

        // Lot full: one deny pulse for a held request, then exit is served.
        count = 3'd7;
        push(FULL, cyc + 1);
        tick(2);
        req_in = 1'b1;
        push(FULL | DENY, cyc + 1);
        push(FULL, cyc + 2);
        tick(10);
        req_out = 1'b1;
        push(FULL | G_OUT | MU, cyc + 1);
        tick(1);
        req_in = 1'b0; req_out = 1'b0;
        complete_cycle(FULL | G_OUT);
        tick(2);

        // Both requests held from reset: grants alternate in, out, in.
        rst = 1'b0;
        count = 3'd2;
        req_in = 1'b1; req_out = 1'b1;
        tick(2);
        rst = 1'b1;
        push(G_IN | MU, cyc + 1);
        complete_cycle(G_IN);
        push(G_OUT | MU, cyc + 1);
        complete_cycle(G_OUT);
        push(G_IN | MU, cyc + 1);
        tick(1);
        req_in = 1'b0; req_out = 1'b0;

        // Safety reopen while closing, then obstruction restarting the hold delay.
        lim_closed = 1'b0;
        tick(2);
        lim_open = 1'b1;
        push(G_IN, cyc + 1);
        tick(1);
        ingreso = 1'b1;
        tick(1);
        ingreso = 1'b0; lim_open = 1'b0;
        push(G_IN | MD, cyc + 1000);
        tick(1003);
        obstr = 1'b1;
        push(G_IN | MU, cyc + 1);
        tick(1);
        obstr = 1'b0;
        tick(3);
        lim_open = 1'b1;
        push(G_IN, cyc + 1);
        tick(1);
        ingreso = 1'b1;
        tick(1);
        ingreso = 1'b0; lim_open = 1'b0;
        tick(499);
        obstr = 1'b1;
        push(G_IN | MD, cyc + 1001);
        tick(1);
        obstr = 1'b0;
        tick(1004);
        lim_closed = 1'b1;
        push(7'd0, cyc + 1);
        tick(2);

        // Both limit switches at once while idle.
        lim_open = 1'b1;
        push(FLT, cyc + 1);
        tick(1);
        lim_open = 1'b0;
        tick(2);
        fault_clr = 1'b1;
        push(7'd0, cyc + 1);
        tick(1);
        fault_clr = 1'b0;
        tick(2);

        // Opening travel timeout.
        req_out = 1'b1;
        push(G_OUT | MU, cyc + 1);
        tick(1);
        req_out = 1'b0; lim_closed = 1'b0;
        push(FLT, cyc + 50000);
        tick(50005);
        fault_clr = 1'b1;
        push(7'd0, cyc + 1);
        tick(1);
        fault_clr = 1'b0;
        tick(1);

        // Back in IDLE: a fresh request is served again.
        lim_closed = 1'b1;
        req_in = 1'b1;
        push(G_IN | MU, cyc + 1);
        tick(1);
        req_in = 1'b0;
        tick(3);

        done = 1'b1;
    end

endmodule

// File: doc/barrera_arbitro.md
Name: barrera_arbitro

Overview:
- Controller for the single shared barrier arm of the one-lane parking lot.
- Arbitrates entry and exit requests and checks occupancy against capacity.
- Sequences the barrier motor using the limit switches, waits for the vehicle-passage pulses from the entry/exit detection FSM, then recloses.
- Sits between the debounced request buttons, the vehicle counter output and the motor driver pins.

Parameters:
CAPACITY, 7, maximum vehicles; entry is denied when count >= CAPACITY
MOTOR_TIMEOUT, 50000, max cycles allowed for open or close travel before fault
PASS_TIMEOUT, 500000, max cycles barrier stays open waiting for passage
CLOSE_DELAY, 1000, cycles barrier is held open after passage detected
TIMER_W, 20, width of the shared cycle timer (must hold the largest of the above)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
req_in  in  1  entry request, level, debounced
req_out  in  1  exit request, level, debounced
count  in  3  current vehicle count from counter
ingreso  in  1  one-cycle pulse: vehicle entered
egreso  in  1  one-cycle pulse: vehicle exited
obstr  in  1  beam under barrier blocked (level)
lim_open  in  1  barrier fully-open limit switch
lim_closed  in  1  barrier fully-closed limit switch
fault_clr  in  1  one-cycle pulse: clear fault
motor_up  out  1  drive barrier upward
motor_down  out  1  drive barrier downward
grant_in  out  1  current cycle serves entry
grant_out  out  1  current cycle serves exit
deny_in  out  1  one-cycle pulse: entry refused, lot full
full  out  1  count >= CAPACITY (registered)
fault  out  1  fault latched

Behaviour:
- Reset (rst=0, async): state IDLE, timer 0, all outputs 0, last_grant=OUT (so the first tie goes to entry), req_in_q 0.
- All outputs are registered. Decisions are made on cycle N and are visible on N+1.
- full is registered from count each cycle, independent of state.
- IDLE: motors off, grants 0.
  - Entry is eligible when req_in=1 and count<CAPACITY. Exit is eligible when req_out=1.
  - Only one eligible: grant it.
  - Both eligible: grant the one opposite to last_grant, then update last_grant.
  - req_in rising edge (req_in=1, req_in_q=0) while count>=CAPACITY and no grant issued: deny_in pulses for 1 cycle. Holding req_in does not re-pulse.
  - Any grant moves to OPENING, clears the timer, and holds the grant line high until return to IDLE.
- OPENING: motor_up=1.
  - lim_open=1 -> WAIT_PASS, timer cleared.
  - timer reaches MOTOR_TIMEOUT-1 -> FAULT.
- WAIT_PASS: motors off.
  - Matching pulse (ingreso when grant_in, egreso when grant_out) -> HOLD, timer cleared.
  - Non-matching pulse is ignored.
  - timer reaches PASS_TIMEOUT-1 -> CLOSING (abandoned request, no error).
- HOLD: motors off. After CLOSE_DELAY cycles -> CLOSING, timer cleared. obstr=1 restarts the timer at 0.
- CLOSING: motor_down=1.
  - lim_closed=1 -> IDLE, grants cleared.
  - obstr=1 -> OPENING immediately (safety reopen), timer cleared, grant kept.
  - timer reaches MOTOR_TIMEOUT-1 -> FAULT.
- FAULT: motors off, grants 0, fault=1. Stays until fault_clr=1 -> IDLE, fault=0.
- lim_open=1 and lim_closed=1 in the same cycle in any non-FAULT state -> FAULT next cycle.
- motor_up and motor_down are never both 1 (must be checked by assertion).
- Requests arriving during a non-IDLE state are not queued. They are re-evaluated on return to IDLE if still asserted.
- Timer saturates and never wraps.

Test Plan:
- rst low mid-OPENING with motor_up=1 -> all outputs 0 asynchronously; after release, state IDLE.
- count=3, req_in=1 -> grant_in=1 and motor_up=1 next cycle; lim_open=1 -> motor_up=0; ingreso pulse -> after 1000 cycles motor_down=1; lim_closed=1 -> IDLE, grant_in=0.
- count=7, req_in rises and is held 10 cycles, req_out=0 -> exactly one deny_in pulse, motors stay 0; then req_out=1 -> grant_out=1.
- req_in=req_out=1 from reset, count=2, three full cycles -> grants go in, out, in.
- During CLOSING, obstr=1 -> motor_down drops and motor_up=1 the next cycle; lim_open -> WAIT_PASS with grant preserved.
- OPENING with lim_open never asserted -> fault=1 after 50000 cycles, motors 0; fault_clr pulse -> fault=0, IDLE.
